multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Upstream sequencer for the multdiv unit, placed between the execute-stage decode and multdiv.
- Accepts one mult/div request per handshake and latches the operands.
- Issues a single-cycle ctrl_MULT/ctrl_DIV pulse and holds the operands stable while multdiv iterates.
- Waits for data_resultRDY, or a timeout, then presents result, exception and destination register to writeback through a valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 64: cycles spent in WAIT before the operation is abandoned.
- RD_BITS, 5: width of the destination-register tag.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_op_mult  in  1  request is a multiply.
- in_op_div  in  1  request is a divide.
- in_operandA  in  32  multiplicand or dividend.
- in_operandB  in  32  multiplier or divisor.
- in_rd  in  RD_BITS  destination-register tag.
- md_operandA  out  32  to multdiv data_operandA.
- md_operandB  out  32  to multdiv data_operandB.
- md_ctrl_MULT  out  1  to multdiv ctrl_MULT.
- md_ctrl_DIV  out  1  to multdiv ctrl_DIV.
- md_result  in  32  from multdiv data_result.
- md_exception  in  1  from multdiv data_exception.
- md_resultRDY  in  1  from multdiv data_resultRDY.
- out_valid  out  1  completed result present.
- out_ready  in  1  writeback accepts the result.
- out_result  out  32  captured result.
- out_exception  out  1  multdiv exception, illegal op, or timeout.
- out_timeout  out  1  completion caused by timeout.
- out_rd  out  RD_BITS  tag of the completed request.
- busy  out  1  state is not IDLE; used as the pipeline stall.

Behaviour:
- Reset values: state IDLE; md_ctrl_MULT, md_ctrl_DIV, out_valid, out_exception, out_timeout and busy are 0; md_operandA/B, out_result and out_rd are 0; counter is 0. in_ready is 0 while reset is high.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered except in_ready = (state==IDLE) & ~reset.
- IDLE:
  - Accept when in_valid & in_ready. Latch the operands into md_operandA/B and latch in_rd.
  - Exactly one op bit set: go to ISSUE.
  - Both op bits set, or neither: illegal. Go directly to DONE with out_exception=1, out_result=0, out_timeout=0. No md_ctrl pulse is issued.
- ISSUE (one cycle):
  - md_ctrl_MULT or md_ctrl_DIV is high for exactly this cycle, matching the latched op.
  - Counter cleared to 0. md_resultRDY is ignored in this cycle because it can be stale from a prior op.
  - Go to WAIT.
- WAIT:
  - md_operandA/B stay constant. Counter increments every cycle.
  - md_resultRDY=1: capture md_result into out_result and md_exception into out_exception, set out_timeout=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with md_resultRDY=0: out_result=0, out_exception=1, out_timeout=1, go to DONE.
  - md_resultRDY and timeout in the same cycle: the result wins.
- DONE:
  - out_valid=1; out_result, out_exception, out_timeout and out_rd are held stable.
  - out_ready=1: out_valid drops on the next edge and the state returns to IDLE. The next request is accepted no earlier than the following cycle, so there is one bubble between requests.
- md_operandA/B keep their last latched values in DONE and IDLE. The ctrl pulses are never asserted outside ISSUE.
- md_resultRDY in IDLE or DONE is ignored.
- Latency: from accept to out_valid is 2 + N cycles, where N is the number of WAIT cycles until md_resultRDY. A legal-op request with immediate md_resultRDY takes 3 cycles. An illegal request reaches out_valid on the cycle after accept.
- Reset mid-operation, in any state: next state is IDLE and all outputs take their reset values. The in-flight multdiv result is discarded, and any later md_resultRDY is ignored in IDLE.
- in_* inputs are don't-care unless accepted.

Test Plan:
- MULT A=7, B=3, in_rd=9 -> exactly one md_ctrl_MULT pulse; out_valid with out_result=21, out_exception=0, out_rd=9; md_operandA/B stay 7/3 throughout WAIT.
- DIV A=7, B=3 -> one md_ctrl_DIV pulse; out_result=2, out_exception=0. Then DIV A=-20, B=4 -> out_result=-5 (0xFFFFFFFB).
- DIV A=5, B=0 -> multdiv exception passes through: out_exception=1, out_result=0, out_timeout=0.
- Hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, busy=1; out_ready=1 -> IDLE next cycle and a new request is accepted one cycle later.
- in_op_mult=1 and in_op_div=1 -> no md_ctrl pulse; out_valid on the cycle after accept with out_exception=1 and out_result=0. Repeat with both op bits 0 -> same response.
- Stub multdiv that never asserts RDY -> out_valid after TIMEOUT_CYCLES WAIT cycles with out_timeout=1 and out_exception=1. Separately, assert reset for 1 cycle mid-WAIT -> state IDLE, all outputs zero; a late md_resultRDY=1 produces no out_valid.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl
//
// Upstream sequencer for the iterative multdiv unit. It sits between
// execute-stage decode and multdiv. It accepts one multiply or divide
// request per handshake and latches the operands. It then fires a
// single-cycle ctrl_MULT/ctrl_DIV pulse and keeps the operands steady
// while multdiv iterates. The completed result is handed to writeback
// through a valid/ready handshake.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   in_valid/in_ready   request handshake from decode
//   in_op_mult/div      operation select (exactly one must be set)
//   in_operandA/B       operands, latched on accept
//   in_rd               destination-register tag, latched on accept
//   md_operandA/B       operands driven to multdiv, held until next accept
//   md_ctrl_MULT/DIV    one-cycle start pulses to multdiv
//   md_result           result returned by multdiv
//   md_exception        exception flag returned by multdiv
//   md_resultRDY        completion flag returned by multdiv
//   out_valid/out_ready result handshake to writeback
//   out_result          captured result (0 on illegal op or timeout)
//   out_exception       multdiv exception, illegal op or timeout
//   out_timeout         completion was caused by the watchdog
//   out_rd              tag of the completed request
//   busy                high whenever the sequencer is not idle (stall)

module multdiv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_BITS        = 5
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_op_mult,
    input  logic               in_op_div,
    input  logic [31:0]        in_operandA,
    input  logic [31:0]        in_operandB,
    input  logic [RD_BITS-1:0] in_rd,

    output logic [31:0]        md_operandA,
    output logic [31:0]        md_operandB,
    output logic               md_ctrl_MULT,
    output logic               md_ctrl_DIV,
    input  logic [31:0]        md_result,
    input  logic               md_exception,
    input  logic               md_resultRDY,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_exception,
    output logic               out_timeout,
    output logic [RD_BITS-1:0] out_rd,

    output logic               busy
);

    // The watchdog counts WAIT cycles starting from 0, so it only needs to
    // reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          opA_q, opA_d;
    logic [31:0]          opB_q, opB_d;
    logic                 ctrlMult_q, ctrlMult_d;
    logic                 ctrlDiv_q, ctrlDiv_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [RD_BITS-1:0]   rdTag_q, rdTag_d;
    logic                 outValid_q, outValid_d;
    logic [31:0]          outResult_q, outResult_d;
    logic                 outExc_q, outExc_d;
    logic                 outTimeout_q, outTimeout_d;
    logic [RD_BITS-1:0]   outRd_q, outRd_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 opLegal;

    // in_ready is the only combinational output. Gating it with reset keeps
    // decode from seeing an accept during the reset cycle.
    assign in_ready = (state_q == IDLE) & ~reset;
    assign accept   = in_valid & in_ready;
    assign opLegal  = in_op_mult ^ in_op_div;

    // Next-state and output computation. Every register holds its value by
    // default. The ctrl pulses default to 0, so they can only be high in the
    // cycle right after an accept, which is the ISSUE cycle.
    always_comb begin
        state_d      = state_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        ctrlMult_d   = 1'b0;
        ctrlDiv_d    = 1'b0;
        count_d      = count_q;
        rdTag_d      = rdTag_q;
        outValid_d   = outValid_q;
        outResult_d  = outResult_q;
        outExc_d     = outExc_q;
        outTimeout_d = outTimeout_q;
        outRd_d      = outRd_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d   = in_operandA;
                    opB_d   = in_operandB;
                    rdTag_d = in_rd;
                    if (opLegal) begin
                        state_d    = ISSUE;
                        ctrlMult_d = in_op_mult;
                        ctrlDiv_d  = in_op_div;
                    end else begin
                        // Illegal op: no multdiv pulse is issued and the
                        // request completes at once as an exception.
                        state_d      = DONE;
                        outValid_d   = 1'b1;
                        outResult_d  = 32'd0;
                        outExc_d     = 1'b1;
                        outTimeout_d = 1'b0;
                        outRd_d      = in_rd;
                    end
                end
            end

            ISSUE: begin
                // md_resultRDY may still be high from the previous
                // operation, so it is ignored here.
                count_d = '0;
                state_d = WAIT;
            end

            WAIT: begin
                count_d = count_q + CNT_W'(1);
                if (md_resultRDY) begin
                    // A result that arrives in the timeout cycle wins.
                    state_d      = DONE;
                    outValid_d   = 1'b1;
                    outResult_d  = md_result;
                    outExc_d     = md_exception;
                    outTimeout_d = 1'b0;
                    outRd_d      = rdTag_q;
                end else if (count_q == CNT_LAST) begin
                    state_d      = DONE;
                    outValid_d   = 1'b1;
                    outResult_d  = 32'd0;
                    outExc_d     = 1'b1;
                    outTimeout_d = 1'b1;
                    outRd_d      = rdTag_q;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    outValid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset discards any in-flight operation.
    // Because the FSM then sits in IDLE, a late md_resultRDY is ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            opA_q        <= 32'd0;
            opB_q        <= 32'd0;
            ctrlMult_q   <= 1'b0;
            ctrlDiv_q    <= 1'b0;
            count_q      <= '0;
            rdTag_q      <= '0;
            outValid_q   <= 1'b0;
            outResult_q  <= 32'd0;
            outExc_q     <= 1'b0;
            outTimeout_q <= 1'b0;
            outRd_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            ctrlMult_q   <= ctrlMult_d;
            ctrlDiv_q    <= ctrlDiv_d;
            count_q      <= count_d;
            rdTag_q      <= rdTag_d;
            outValid_q   <= outValid_d;
            outResult_q  <= outResult_d;
            outExc_q     <= outExc_d;
            outTimeout_q <= outTimeout_d;
            outRd_q      <= outRd_d;
            busy_q       <= busy_d;
        end
    end

    assign md_operandA   = opA_q;
    assign md_operandB   = opB_q;
    assign md_ctrl_MULT  = ctrlMult_q;
    assign md_ctrl_DIV   = ctrlDiv_q;
    assign out_valid     = outValid_q;
    assign out_result    = outResult_q;
    assign out_exception = outExc_q;
    assign out_timeout   = outTimeout_q;
    assign out_rd        = outRd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Testbench for multdiv_issue_ctrl.
// The bench plays both decode and a stub multdiv. A behavioural model
// derives each request's expected result, flags and completion cycle
// from the operation, the operands and the stub's chosen latency.

module tb_multdiv_issue_ctrl;

    localparam int T   = 64;
    localparam int RDB = 5;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            in_op_mult;
    logic            in_op_div;
    logic [31:0]     in_operandA;
    logic [31:0]     in_operandB;
    logic [RDB-1:0]  in_rd;
    logic [31:0]     md_operandA;
    logic [31:0]     md_operandB;
    logic            md_ctrl_MULT;
    logic            md_ctrl_DIV;
    logic [31:0]     md_result;
    logic            md_exception;
    logic            md_resultRDY;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic            out_exception;
    logic            out_timeout;
    logic [RDB-1:0]  out_rd;
    logic            busy;

    int checkCount = 0;
    int passCount  = 0;

    multdiv_issue_ctrl #(
        .TIMEOUT_CYCLES(T),
        .RD_BITS(RDB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op_mult(in_op_mult),
        .in_op_div(in_op_div),
        .in_operandA(in_operandA),
        .in_operandB(in_operandB),
        .in_rd(in_rd),
        .md_operandA(md_operandA),
        .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT),
        .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result),
        .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_exception(out_exception),
        .out_timeout(out_timeout),
        .out_rd(out_rd),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    // Advance one cycle, then settle just past the edge for driving and sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: multiply is the low 32 bits of the product. Divide is
    // signed and truncates toward zero. Divide by zero raises an exception
    // with a zero result.
    function automatic logic [31:0] refMult(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    function automatic logic [31:0] refDiv(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (sb == 0) return 32'd0;
        return 32'(sa / sb);
    endfunction

    // One complete request.
    // op: 0 = mult, 1 = div, 2 = both bits set, 3 = neither bit set.
    // lat: WAIT cycle in which the stub raises RDY (> T means the stub never does).
    // hold: DONE cycles with out_ready low before writeback accepts.
    // stale: drive a stale RDY during ISSUE and garbage RDY during DONE.
    task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [RDB-1:0] rd, input int lat, input int hold,
                                 input bit stale);
        logic        isMult;
        logic        isDiv;
        bit          legal;
        logic [31:0] stubRes;
        logic        stubExc;
        logic [31:0] expRes;
        logic        expExc;
        logic        expTo;
        int          doneAfter;

        isMult = (op == 0) || (op == 2);
        isDiv  = (op == 1) || (op == 2);
        legal  = (op < 2);
        stubRes = isMult ? refMult(a, b) : refDiv(a, b);
        stubExc = (op == 1) && (b == 32'd0);

        if (!legal) begin
            expRes = 32'd0; expExc = 1'b1; expTo = 1'b0;
        end else if (lat > T) begin
            expRes = 32'd0; expExc = 1'b1; expTo = 1'b1;
        end else begin
            expRes = stubRes; expExc = stubExc; expTo = 1'b0;
        end

        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_op_mult  = isMult;
        in_op_div   = isDiv;
        in_operandA = a;
        in_operandB = b;
        in_rd       = rd;
        tick();
        in_valid    = 1'b0;
        in_op_mult  = 1'($urandom_range(0, 1));
        in_op_div   = 1'($urandom_range(0, 1));
        in_operandA = $urandom;
        in_operandB = $urandom;
        in_rd       = RDB'($urandom);

        if (legal) begin
            checkOutput("issue_mult_pulse", 32'(md_ctrl_MULT), 32'(isMult));
            checkOutput("issue_div_pulse", 32'(md_ctrl_DIV), 32'(isDiv));
            checkOutput("issue_opA", md_operandA, a);
            checkOutput("issue_opB", md_operandB, b);
            checkOutput("issue_busy", 32'(busy), 32'd1);
            checkOutput("issue_in_ready", 32'(in_ready), 32'd0);
            checkOutput("issue_out_valid", 32'(out_valid), 32'd0);
            if (stale) begin
                md_resultRDY = 1'b1;
                md_result    = 32'hDEADBEEF;
                md_exception = 1'b1;
            end
            tick();
            md_resultRDY = 1'b0;
            doneAfter = (lat <= T) ? lat : T;
            for (int n = 1; n <= doneAfter; n++) begin
                checkOutput("wait_out_valid", 32'(out_valid), 32'd0);
                checkOutput("wait_no_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
                checkOutput("wait_opA", md_operandA, a);
                checkOutput("wait_opB", md_operandB, b);
                if (n == lat) begin
                    md_resultRDY = 1'b1;
                    md_result    = stubRes;
                    md_exception = stubExc;
                end else begin
                    md_result    = $urandom;
                    md_exception = 1'($urandom_range(0, 1));
                end
                tick();
                md_resultRDY = 1'b0;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            checkOutput("done_out_valid", 32'(out_valid), 32'd1);
            checkOutput("done_result", out_result, expRes);
            checkOutput("done_exception", 32'(out_exception), 32'(expExc));
            checkOutput("done_timeout", 32'(out_timeout), 32'(expTo));
            checkOutput("done_rd", 32'(out_rd), 32'(rd));
            checkOutput("done_busy", 32'(busy), 32'd1);
            checkOutput("done_in_ready", 32'(in_ready), 32'd0);
            checkOutput("done_no_pulse", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
            checkOutput("done_opA", md_operandA, a);
            if (h < hold) begin
                out_ready = 1'b0;
                if (stale) begin
                    md_resultRDY = 1'b1;
                    md_result    = $urandom;
                    md_exception = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready    = 1'b0;
        md_resultRDY = 1'b0;
        checkOutput("ret_out_valid", 32'(out_valid), 32'd0);
        checkOutput("ret_busy", 32'(busy), 32'd0);
        checkOutput("ret_in_ready", 32'(in_ready), 32'd1);
        checkOutput("ret_opB_kept", md_operandB, b);
    endtask

    initial begin
        int          op;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_op_mult   = 1'b0;
        in_op_div    = 1'b0;
        in_operandA  = 32'd0;
        in_operandB  = 32'd0;
        in_rd        = '0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        out_ready    = 1'b0;

        tick();
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pulses", {30'd0, md_ctrl_MULT, md_ctrl_DIV}, 32'd0);
        checkOutput("reset_flags", {30'd0, out_exception, out_timeout}, 32'd0);
        checkOutput("reset_result", out_result, 32'd0);
        checkOutput("reset_rd", 32'(out_rd), 32'd0);
        checkOutput("reset_opA", md_operandA, 32'd0);
        checkOutput("reset_opB", md_operandB, 32'd0);
        checkOutput("reset_released_in_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        applyStimulus(0, 32'd7, 32'd3, 5'd9, 4, 0, 1'b0);
        applyStimulus(1, 32'd7, 32'd3, 5'd1, 2, 0, 1'b1);
        applyStimulus(1, 32'hFFFFFFEC, 32'd4, 5'd2, 1, 0, 1'b0);
        applyStimulus(1, 32'd5, 32'd0, 5'd3, 3, 0, 1'b0);
        applyStimulus(0, 32'd12, 32'd12, 5'd4, 1, 10, 1'b1);
        applyStimulus(2, 32'd11, 32'd13, 5'd5, 1, 2, 1'b0);
        applyStimulus(3, 32'd11, 32'd13, 5'd6, 1, 0, 1'b0);
        applyStimulus(0, 32'd2, 32'd3, 5'd7, T + 5, 1, 1'b0);
        applyStimulus(1, 32'd100, 32'd7, 5'd8, T, 0, 1'b0);

        // Reset in the middle of WAIT.
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_op_mult  = 1'b1;
        in_op_div   = 1'b0;
        in_operandA = 32'd9;
        in_operandB = 32'd9;
        in_rd       = 5'd31;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_opA", md_operandA, 32'd0);
        checkOutput("rst_mid_opB", md_operandB, 32'd0);
        checkOutput("rst_mid_rd", 32'(out_rd), 32'd0);
        checkOutput("rst_mid_in_ready_high", 32'(in_ready), 32'd1);
        md_resultRDY = 1'b1;
        md_result    = 32'd81;
        tick();
        md_resultRDY = 1'b0;
        checkOutput("rst_late_rdy_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_late_rdy_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("rst_late_rdy_result", out_result, 32'd0);

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            op = (op < 4) ? 0 : (op < 8) ? 1 : (op == 8) ? 2 : 3;
            a = $urandom;
            b = $urandom;
            if (op == 1) begin
                b = 32'($urandom_range(0, 40)) - 32'd20;
                if (a == 32'h80000000) a = 32'd1;
            end
            lat = ($urandom_range(0, 7) == 0) ? T + 1 : int'($urandom_range(1, 8));
            applyStimulus(op, a, b, RDB'($urandom), lat, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
